uart_tx_fifo: RTL and testbench

- Byte buffer directly upstream of the UART transmitter.
- Accepts bytes from the CPU memory-mapped IO path via a valid/ready enqueue port and holds them in order.
- Presents bytes to the transmitter's data_in/data_in_valid/data_in_ready handshake.
- Lets software queue several bytes while the serial line drains at baud rate, and exposes occupancy for a status register.

---
 rtl/fifo_mem.sv | 35 +++
 rtl/uart_tx_fifo.sv | 81 ++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mem.sv
// Storage array for the UART transmit FIFO: one synchronous write port and one
// combinational read port so the head byte can fall through to the transmitter.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] entries [DEPTH];

    // One register per entry; contents are deliberately left unreset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    entry_reg <= wdata;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign rdata = entries[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO sitting between the CPU IO write path and
// the UART transmitter; exposes occupancy for the status register.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;

    // Extra wrap bit distinguishes full from empty when the addresses match.
    assign empty = (rd_ptr_reg == wr_ptr_reg);
    assign full  = (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]) &&
                   (rd_ptr_reg[AW] != wr_ptr_reg[AW]);

    // Ready depends only on state, flush and reset, never on the transmitter.
    assign enq_ready = ~full & ~flush & rst_n;
    assign deq_valid = ~empty & ~flush;

    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_valid & deq_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (enq_fire) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else if (deq_fire) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    assign count = wr_ptr_reg - rd_ptr_reg;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (enq_fire),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (enq_data),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (deq_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (WIDTH=8, DEPTH=16).
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] enq_data;
    logic       enq_valid;
    logic       enq_ready;
    logic [7:0] deq_data;
    logic       deq_valid;
    logic       deq_ready;
    logic       flush;
    logic [4:0] count;

    int tests_run;
    int tests_failed;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_data  (enq_data),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .deq_data  (deq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        enq_valid = 1'b1;
        enq_data  = b;
        #1;
        check("push_ready", 32'(enq_ready), 32'd1);
        $display("[TB] enq 0x%02h", b);
        step();
        enq_valid = 1'b0;
    endtask

    task automatic pop(input logic [7:0] exp);
        deq_ready = 1'b1;
        #1;
        check("pop_valid", 32'(deq_valid), 32'd1);
        check("pop_data", 32'(deq_data), 32'(exp));
        $display("[TB] deq 0x%02h (expect 0x%02h)", deq_data, exp);
        step();
        deq_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        enq_data  = 8'h00;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 32'd0);
        check("rst_deq_valid", 32'(deq_valid), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_enq_ready", 32'(enq_ready), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

        // 1: three bytes in, out in order
        push(8'h41);
        push(8'h42);
        push(8'h43);
        #1;
        check("t1_count", 32'(count), 32'd3);
        check("t1_deq_valid", 32'(deq_valid), 32'd1);
        check("t1_head", 32'(deq_data), 32'h41);
        pop(8'h41);
        pop(8'h42);
        pop(8'h43);
        #1;
        check("t1_empty_count", 32'(count), 32'd0);
        check("t1_empty_valid", 32'(deq_valid), 32'd0);

        // 2: fill to 16, 17th refused
        for (int i = 0; i < 16; i++) push(8'(i));
        #1;
        check("t2_full_count", 32'(count), 32'd16);
        check("t2_full_ready", 32'(enq_ready), 32'd0);
        enq_valid = 1'b1;
        enq_data  = 8'hFF;
        #1;
        check("t2_17th_ready", 32'(enq_ready), 32'd0);
        step();
        enq_valid = 1'b0;
        #1;
        check("t2_17th_count", 32'(count), 32'd16);

        // 3: full with simultaneous enq and deq: only deq fires
        enq_valid = 1'b1;
        enq_data  = 8'hFE;
        deq_ready = 1'b1;
        #1;
        check("t3_enq_ready", 32'(enq_ready), 32'd0);
        check("t3_head", 32'(deq_data), 32'h00);
        step();
        deq_ready = 1'b0;
        #1;
        check("t3_count15", 32'(count), 32'd15);
        check("t3_space_ready", 32'(enq_ready), 32'd1);
        step();
        enq_valid = 1'b0;
        #1;
        check("t3_count16", 32'(count), 32'd16);
        for (int i = 1; i < 16; i++) pop(8'(i));
        pop(8'hFE);
        #1;
        check("t3_drained", 32'(count), 32'd0);

        // 4: steady stream at count=4 across pointer wraps
        for (int i = 0; i < 4; i++) push(8'(8'h80 + i));
        for (int i = 0; i < 40; i++) begin
            enq_valid = 1'b1;
            enq_data  = 8'(8'h84 + i);
            deq_ready = 1'b1;
            #1;
            check("t4_data", 32'(deq_data), 32'(8'(8'h80 + i)));
            check("t4_count", 32'(count), 32'd4);
            $display("[TB] stream enq 0x%02h deq 0x%02h", enq_data, deq_data);
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        check("t4_end_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop(8'(8'hA8 + i));

        // 5: flush with both handshakes requested
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 8'hEE;
        deq_ready = 1'b1;
        #1;
        check("t5_flush_valid", 32'(deq_valid), 32'd0);
        check("t5_flush_ready", 32'(enq_ready), 32'd0);
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        #1;
        check("t5_count", 32'(count), 32'd0);
        check("t5_deq_valid", 32'(deq_valid), 32'd0);
        check("t5_enq_ready", 32'(enq_ready), 32'd1);

        // 6: async reset mid-operation
        for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
        #1;
        check("t6_count7", 32'(count), 32'd7);
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_valid", 32'(deq_valid), 32'd0);
        check("t6_rst_ready", 32'(enq_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("t6_rel_ready", 32'(enq_ready), 32'd1);
        enq_valid = 1'b1;
        enq_data  = 8'h5A;
        #1;
        check("t6_no_bypass", 32'(deq_valid), 32'd0);
        step();
        enq_valid = 1'b0;
        #1;
        check("t6_valid", 32'(deq_valid), 32'd1);
        check("t6_data", 32'(deq_data), 32'h5A);
        check("t6_count1", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
